// File: rtl/adc_trig_pkg.sv
// Shared constants for the ADC trigger sequencer.
// Covers the FSM state encodings, the trigger-source modes and the sample geometry.
package adc_trig_pkg;

    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 16;
    localparam int CHAN_W   = 3;
    localparam int CNT_W    = 16;

    typedef logic [1:0] state_t;

    // state        | meaning
    // ST_IDLE      | not armed, only force or arm act
    // ST_ARMED     | waiting for a qualified trigger
    // ST_WAIT_DONE | trigger issued, waiting for capture memory to fill
    // ST_HOLDOFF   | post-capture dead time, then re-arm or idle
    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_ARMED     = 2'd1;
    localparam state_t ST_WAIT_DONE = 2'd2;
    localparam state_t ST_HOLDOFF   = 2'd3;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FORCE = 2'd0;
    localparam mode_t MODE_EXT   = 2'd1;
    localparam mode_t MODE_LEVEL = 2'd2;
    localparam mode_t MODE_BOTH  = 2'd3;

endpackage

// File: rtl/adc_level_cross.sv
// Signed threshold crossing detector working on the previous and current samples.
// A crossing is reported only when the earlier sample was strictly on the far side of the level.
module adc_level_cross
    import adc_trig_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] i_prev,
    input  logic signed [SAMPLE_W-1:0] i_cur,
    input  logic signed [SAMPLE_W-1:0] i_level,
    input  logic                       i_edge_pol,
    output logic                       o_cross
);

    logic w_rise;
    logic w_fall;

    assign w_rise  = (i_prev < i_level) && (i_cur >= i_level);
    assign w_fall  = (i_prev > i_level) && (i_cur <= i_level);
    assign o_cross = i_edge_pol ? w_fall : w_rise;

endmodule

// File: rtl/adc_trig_seq.sv
// ADC trigger sequencer: arms, qualifies level/external/forced triggers, and
// sequences capture completion and holdoff before returning to armed or idle.
module adc_trig_seq
    import adc_trig_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
    input  logic [CHAN_W-1:0]          chan_sel,
    input  logic [SAMPLE_W-1:0]        level,
    input  logic                       edge_pol,
    input  logic [1:0]                 mode,
    input  logic                       ext_trig,
    input  logic                       arm,
    input  logic                       disarm,
    input  logic                       force_req,
    input  logic [CNT_W-1:0]           holdoff,
    input  logic                       auto_rearm,
    input  logic                       capture_done,
    output logic                       trig_out,
    output logic [1:0]                 state,
    output logic [CNT_W-1:0]           trig_count
);

    state_t                     r_state;
    logic                       r_trig;
    logic [CNT_W-1:0]           r_count;
    logic [CNT_W-1:0]           r_hold_cnt;
    logic signed [SAMPLE_W-1:0] r_cur;
    logic signed [SAMPLE_W-1:0] r_prev;
    logic                       r_ext_q;
    logic                       r_ext_qq;

    state_t                     w_state_nxt;
    logic                       w_fire;
    logic                       w_load;
    logic [SAMPLE_W-1:0]        w_sel;
    logic                       w_lvl_evt;
    logic                       w_ext_evt;
    logic                       w_src_evt;

    assign w_sel = adc_data[chan_sel*SAMPLE_W +: SAMPLE_W];

    adc_level_cross u_level_cross (
        .i_prev     (r_prev),
        .i_cur      (r_cur),
        .i_level    ($signed(level)),
        .i_edge_pol (edge_pol),
        .o_cross    (w_lvl_evt)
    );

    // Edge taken from two registered copies so ext and level events share the same latency.
    assign w_ext_evt = r_ext_q & ~r_ext_qq;
    assign w_src_evt = (((mode == MODE_EXT)   || (mode == MODE_BOTH)) && w_ext_evt) ||
                       (((mode == MODE_LEVEL) || (mode == MODE_BOTH)) && w_lvl_evt);

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (disarm) begin
                    w_state_nxt = ST_IDLE;
                end else if (force_req) begin
                    w_state_nxt = ST_WAIT_DONE;
                    w_fire      = 1'b1;
                end else if (arm) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (disarm) begin
                    w_state_nxt = ST_IDLE;
                end else if (force_req || w_src_evt) begin
                    w_state_nxt = ST_WAIT_DONE;
                    w_fire      = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (capture_done) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_load      = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (disarm) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_hold_cnt == '0) begin
                    w_state_nxt = auto_rearm ? ST_ARMED : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_trig     <= 1'b0;
            r_count    <= '0;
            r_hold_cnt <= '0;
            r_cur      <= '0;
            r_prev     <= '0;
            r_ext_q    <= 1'b0;
            r_ext_qq   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trig   <= w_fire;
            r_cur    <= $signed(w_sel);
            r_prev   <= r_cur;
            r_ext_q  <= ext_trig;
            r_ext_qq <= r_ext_q;
            if (w_fire) begin
                r_count <= r_count + 16'd1;
            end
            if (w_load) begin
                r_hold_cnt <= holdoff;
            end else if ((r_state == ST_HOLDOFF) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 16'd1;
            end
        end
    end

    assign trig_out   = r_trig;
    assign state      = r_state;
    assign trig_count = r_count;

endmodule

// File: tb/tb_adc_trig_seq.sv
// Directed bench for adc_trig_seq: level rise/fall, ext with holdoff, strobe
// priority, mid-capture reset and trigger counter wrap.
module tb_adc_trig_seq;

    logic         clk;
    logic         rst;
    logic [127:0] adc_data;
    logic [2:0]   chan_sel;
    logic [15:0]  level;
    logic         edge_pol;
    logic [1:0]   mode;
    logic         ext_trig;
    logic         arm;
    logic         disarm;
    logic         force_req;
    logic [15:0]  holdoff;
    logic         auto_rearm;
    logic         capture_done;
    logic         trig_out;
    logic [1:0]   state;
    logic [15:0]  trig_count;

    int n_checks = 0;
    int n_errors = 0;

    adc_trig_seq dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .chan_sel     (chan_sel),
        .level        (level),
        .edge_pol     (edge_pol),
        .mode         (mode),
        .ext_trig     (ext_trig),
        .arm          (arm),
        .disarm       (disarm),
        .force_req    (force_req),
        .holdoff      (holdoff),
        .auto_rearm   (auto_rearm),
        .capture_done (capture_done),
        .trig_out     (trig_out),
        .state        (state),
        .trig_count   (trig_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int ch, input int val);
        adc_data[ch*16 +: 16] = 16'(val);
    endtask

    initial begin
        int pulses;
        int n;

        rst = 1'b1; adc_data = '0; chan_sel = 3'd0; level = 16'd0; edge_pol = 1'b0;
        mode = 2'd0; ext_trig = 1'b0; arm = 1'b0; disarm = 1'b0; force_req = 1'b0;
        holdoff = 16'd0; auto_rearm = 1'b0; capture_done = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_trig", 32'(trig_out), 32'd0);
        chk("rst_count", 32'(trig_count), 32'd0);
        rst = 1'b0;

        // level rising on channel 3
        mode = 2'd2; chan_sel = 3'd3; level = 16'd100; edge_pol = 1'b0;
        set_ch(3, 90);
        tick(); tick(); tick();
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_state", 32'(state), 32'd1);
        set_ch(3, 99); tick();
        chk("rise_99", 32'(trig_out), 32'd0);
        set_ch(3, 100); tick();
        chk("rise_lat1", 32'(trig_out), 32'd0);
        tick();
        chk("rise_trig", 32'(trig_out), 32'd1);
        chk("rise_state", 32'(state), 32'd2);
        chk("rise_count", 32'(trig_count), 32'd1);
        tick();
        chk("rise_pulse", 32'(trig_out), 32'd0);
        capture_done = 1'b1; tick(); capture_done = 1'b0;
        chk("hold0_state", 32'(state), 32'd3);
        tick();
        chk("hold0_idle", 32'(state), 32'd0);

        // falling threshold, channel already below level when armed
        chan_sel = 3'd0; edge_pol = 1'b1; level = 16'hFFCE;
        set_ch(0, -60);
        tick(); tick(); tick();
        arm = 1'b1; tick(); arm = 1'b0;
        chk("fall_arm_trig", 32'(trig_out), 32'd0);
        tick();
        chk("fall_m60", 32'(trig_out), 32'd0);
        set_ch(0, -40); tick();
        chk("fall_m40", 32'(trig_out), 32'd0);
        tick();
        chk("fall_m40b", 32'(trig_out), 32'd0);
        set_ch(0, -50); tick();
        chk("fall_lat1", 32'(trig_out), 32'd0);
        tick();
        chk("fall_trig", 32'(trig_out), 32'd1);
        chk("fall_count", 32'(trig_count), 32'd2);
        capture_done = 1'b1; tick(); capture_done = 1'b0;
        tick();
        chk("fall_idle", 32'(state), 32'd0);

        // ext trigger held high, holdoff 5 with auto re-arm
        mode = 2'd1;
        arm = 1'b1; tick(); arm = 1'b0;
        ext_trig = 1'b1; tick();
        chk("ext_lat1", 32'(trig_out), 32'd0);
        tick();
        chk("ext_trig", 32'(trig_out), 32'd1);
        pulses = 1;
        repeat (8) begin
            tick();
            if (trig_out) pulses++;
        end
        chk("ext_single", 32'(pulses), 32'd1);
        chk("ext_count", 32'(trig_count), 32'd3);
        ext_trig = 1'b0;
        holdoff = 16'd5; auto_rearm = 1'b1;
        capture_done = 1'b1; tick(); capture_done = 1'b0;
        n = 0;
        while (state == 2'd3 && n < 20) begin
            n++;
            tick();
        end
        chk("holdoff_cycles", 32'(n), 32'd6);
        chk("rearm_state", 32'(state), 32'd1);

        // strobe priority
        disarm = 1'b1; force_req = 1'b1; tick(); disarm = 1'b0; force_req = 1'b0;
        chk("disarm_force_st", 32'(state), 32'd0);
        chk("disarm_force_tr", 32'(trig_out), 32'd0);
        mode = 2'd0; holdoff = 16'd0; auto_rearm = 1'b0;
        force_req = 1'b1; arm = 1'b1; tick(); force_req = 1'b0; arm = 1'b0;
        chk("force_arm_trig", 32'(trig_out), 32'd1);
        chk("force_arm_st", 32'(state), 32'd2);
        chk("force_arm_cnt", 32'(trig_count), 32'd4);
        disarm = 1'b1; tick(); disarm = 1'b0;
        chk("wait_disarm", 32'(state), 32'd2);
        force_req = 1'b1; tick(); force_req = 1'b0;
        chk("wait_force_tr", 32'(trig_out), 32'd0);
        chk("wait_force_cnt", 32'(trig_count), 32'd4);

        // reset during WAIT_DONE
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_count", 32'(trig_count), 32'd0);
        capture_done = 1'b1; tick(); capture_done = 1'b0;
        chk("late_done", 32'(state), 32'd0);

        // counter wrap: force and capture_done held, 3 cycles per trigger
        force_req = 1'b1; capture_done = 1'b1;
        repeat (65535 * 3) tick();
        chk("wrap_ffff", 32'(trig_count), 32'd65535);
        chk("wrap_state", 32'(state), 32'd0);
        repeat (3) tick();
        force_req = 1'b0; capture_done = 1'b0;
        chk("wrap_zero", 32'(trig_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_trig_seq.md
ADC_TRIG_SEQ -- requirements
Module: adc_trig_seq

Interface
REQ-001 SHALL have port: clk  input  1  ADC sample clock, sole clock; all logic on its rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: adc_data  input  128  8 channels x 16-bit signed; channel n in bits [16n+15:16n].
REQ-004 SHALL have ports: chan_sel input 3, selected channel; level input 16, signed threshold; edge_pol input 1, 0 = rising, 1 = falling.
REQ-005 SHALL have port: mode  input  2  trigger source: 0 = force only; 1 = ext; 2 = level; 3 = ext OR level.
REQ-006 SHALL have ports: ext_trig input 1, external trigger, level-sensitive, already in clk domain; arm, disarm, force input 1 each, single-cycle host strobes.
REQ-007 SHALL have ports: holdoff input 16, post-capture dead time in cycles; auto_rearm input 1.
REQ-008 SHALL have port: capture_done  input  1  single-cycle pulse from the downstream capture memory when the fill completes.
REQ-009 SHALL have ports: trig_out output 1, single-cycle, feeds the capture raw-trigger input; state output 2; trig_count output 16.

Function
REQ-010 SHALL implement states IDLE=0, ARMED=1, WAIT_DONE=2, HOLDOFF=3, reported on state.
REQ-011 SHALL move IDLE->ARMED on arm.
REQ-012 SHALL move ARMED->WAIT_DONE on a qualified trigger.
- Qualified trigger: enabled source event, or force.
REQ-013 SHALL move WAIT_DONE->HOLDOFF on capture_done, loading the counter with holdoff.
REQ-014 SHALL handle HOLDOFF as follows:
- Counter nonzero: decrement.
- Counter zero: go to ARMED if auto_rearm, else IDLE.
- holdoff=0 therefore gives exactly one HOLDOFF cycle.
REQ-015 SHALL accept force in IDLE or ARMED: pulse trig_out and go to WAIT_DONE; force SHALL be ignored in WAIT_DONE and HOLDOFF.
REQ-016 SHALL return to IDLE from ARMED or HOLDOFF on disarm; disarm SHALL be ignored in WAIT_DONE.
REQ-017 SHALL give priority disarm > force > arm when strobes coincide.
REQ-018 SHALL register the selected sample every cycle into cur, and cur into prev.
REQ-019 SHALL detect a level event, signed compare, as:
- Rising: prev < level and cur >= level.
- Falling: prev > level and cur <= level.
REQ-020 SHALL detect an ext event as a registered rising edge of ext_trig; a held-high ext_trig SHALL produce one event only.
REQ-021 SHALL assert trig_out exactly 2 cycles after the triggering sample or ext_trig edge is presented at the inputs, and 1 cycle after a force strobe.
REQ-022 SHALL ignore source events outside ARMED, and ignore capture_done outside WAIT_DONE.
REQ-023 SHALL increment trig_count on every trig_out pulse, wrapping modulo 2^16.
REQ-024 SHALL sample chan_sel, level, edge_pol and mode live; a change while ARMED may cause at most one spurious compare cycle.

Reset
REQ-025 SHALL set on rst: state=IDLE, trig_out=0, trig_count=0, holdoff counter=0, cur=prev=0, ext edge register=0; rst asserted mid-operation SHALL abort any state on the next edge.

Structure
REQ-026 SHALL take its state typedef, mode encodings and channel count/width constants from shared package adc_trig_pkg.
REQ-027 SHALL place the signed crossing comparator (REQ-019) in sub-module adc_level_cross.

Verification
REQ-028 SHALL cover a level rising event:
- Stimulus: mode=2, chan_sel=3, level=100, arm; ch3 ramps 90,99,100.
- Response: one trig_out 2 cycles after the sample 100, state=2, trig_count=1.
REQ-029 SHALL cover a falling threshold with initial value already below:
- Stimulus: edge_pol=1, level=-50, arm while ch0=-60; ch0 then -60,-40,-50.
- Response: no trigger on arm, trigger only on the -50 sample.
REQ-030 SHALL cover ext trigger with holdoff and re-arm:
- Stimulus: mode=1, ext_trig held high 10 cycles, capture_done, holdoff=5, auto_rearm=1.
- Response: a single trig_out; 6 HOLDOFF cycles; then ARMED.
REQ-031 SHALL cover strobe priority: force+arm in IDLE -> trig_out after 1 cycle, WAIT_DONE; disarm+force in ARMED -> IDLE, no trig_out.
REQ-032 SHALL cover reset and counter wrap:
- Stimulus: rst during WAIT_DONE.
- Response: IDLE, trig_count=0, the later capture_done is ignored.
- Stimulus: 65536 forced captures.
- Response: trig_count=0.
